// File: rtl/sha1_pkg.sv
// Shared definitions for the SHA-1 message padder: FSM state encoding,
// block geometry, padding constants and the final-word byte masking helper.
package sha1_pkg;

  localparam int unsigned WORD_W      = 32;
  localparam int unsigned BLOCK_WORDS = 16;
  localparam int unsigned BLK_W       = WORD_W * BLOCK_WORDS;
  localparam int unsigned WIDX_W      = 4;
  localparam int unsigned CNT_W       = 64;
  localparam int unsigned LEN_WORD_HI = 14;
  localparam int unsigned LEN_WORD_LO = 15;

  localparam logic [7:0]        PAD_BYTE = 8'h80;
  localparam logic [WORD_W-1:0] PAD_WORD = {PAD_BYTE, 24'h000000};

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_PAD   = 2'd1,
    ST_ISSUE = 2'd2,
    ST_WAIT  = 2'd3
  } state_t;

  // Keep the MSB-aligned valid bytes of a final word, append the pad byte
  // right after them and zero the rest. nbytes==0 means a full word (no pad here).
  function automatic logic [WORD_W-1:0] final_word(input logic [WORD_W-1:0] data,
                                                   input logic [1:0]        nbytes);
    logic [WORD_W-1:0] w;
    w = data;
    case (nbytes)
      2'd1:    w = {data[31:24], PAD_BYTE, 16'h0000};
      2'd2:    w = {data[31:16], PAD_BYTE, 8'h00};
      2'd3:    w = {data[31:8],  PAD_BYTE};
      default: w = data;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/sha1_msg_padder.sv
// SHA-1 message padder: collects big-endian 32-bit message words into a
// 16-word block buffer, applies the 0x80 / zero-fill / 64-bit length padding,
// and hands each 512-bit block to the hash core with init/next handshakes.
//
// Ports
//   clk, reset_n        clock, async active-low reset
//   s_valid/s_ready     message word handshake
//   s_data              message word, first byte in [31:24]
//   s_last, s_bytes     final-word marker and its valid byte count (0 = 4)
//   blk                 padded block, word 0 at [511:480]
//   blk_init, blk_next  one-cycle issue pulses (first / later block)
//   core_ready          hash core can take a block
//   core_digest_valid   hash core finished the current block
//   msg_done            one-cycle pulse after the final block's digest
//   busy                message in progress
module sha1_msg_padder
  import sha1_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [WORD_W-1:0]  s_data,
  input  logic               s_last,
  input  logic [1:0]         s_bytes,
  output logic [BLK_W-1:0]   blk,
  output logic               blk_init,
  output logic               blk_next,
  input  logic               core_ready,
  input  logic               core_digest_valid,
  output logic               msg_done,
  output logic               busy
);

  state_t r_state;
  state_t w_state_nxt;

  logic [WORD_W-1:0] r_buf [BLOCK_WORDS];
  logic [WIDX_W-1:0] r_widx;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_first;
  logic              r_pend_extra;
  logic              r_carry;
  logic              r_k4;
  logic              r_final;
  logic              r_s_ready;
  logic              r_blk_init;
  logic              r_blk_next;
  logic              r_msg_done;
  logic              r_busy;

  logic              w_hs;
  logic              w_issue_go;
  logic              w_wait_done;
  logic [CNT_W-1:0]  w_add;
  logic [WIDX_W:0]   w_padw;

  // Bits contributed by the word being accepted.
  assign w_add = (s_last && (s_bytes != 2'd0)) ? CNT_W'({s_bytes, 3'b000}) : CNT_W'(WORD_W);

  // Word index holding the pad byte; 16 means it spills into the next block.
  assign w_padw = {1'b0, r_widx} + (WIDX_W+1)'(r_k4);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_FILL;
    else          r_state <= w_state_nxt;
  end

  // Next-state and handshake decode.
  always_comb begin
    w_state_nxt = r_state;
    w_hs        = 1'b0;
    w_issue_go  = 1'b0;
    w_wait_done = 1'b0;
    case (r_state)
      ST_FILL: begin
        w_hs = s_valid && r_s_ready;
        if (w_hs) begin
          if (s_last)                                  w_state_nxt = ST_PAD;
          else if (r_widx == WIDX_W'(BLOCK_WORDS - 1)) w_state_nxt = ST_ISSUE;
        end
      end
      ST_PAD:  w_state_nxt = ST_ISSUE;
      ST_ISSUE: begin
        if (core_ready) begin
          w_issue_go  = 1'b1;
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (core_digest_valid) begin
          w_wait_done = 1'b1;
          w_state_nxt = (!r_final && r_pend_extra) ? ST_PAD : ST_FILL;
        end
      end
      default: w_state_nxt = ST_FILL;
    endcase
  end

  // Buffer, counters, flags and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned j = 0; j < BLOCK_WORDS; j++) r_buf[j] <= '0;
      r_widx       <= '0;
      r_cnt        <= '0;
      r_first      <= 1'b1;
      r_pend_extra <= 1'b0;
      r_carry      <= 1'b0;
      r_k4         <= 1'b0;
      r_final      <= 1'b0;
      r_s_ready    <= 1'b0;
      r_blk_init   <= 1'b0;
      r_blk_next   <= 1'b0;
      r_msg_done   <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_s_ready  <= (w_state_nxt == ST_FILL);
      r_blk_init <= w_issue_go && r_first;
      r_blk_next <= w_issue_go && !r_first;
      r_msg_done <= w_wait_done && r_final;

      if (w_hs) begin
        r_busy <= 1'b1;
        r_cnt  <= r_cnt + w_add;
        if (s_last) begin
          // widx stays on the final word so PAD knows where data ends.
          r_buf[r_widx] <= final_word(s_data, s_bytes);
          r_k4          <= (s_bytes == 2'd0);
        end else begin
          r_buf[r_widx] <= s_data;
          r_widx        <= r_widx + WIDX_W'(1);
          r_final       <= 1'b0;
        end
      end

      if (r_state == ST_PAD) begin
        if (r_pend_extra) begin
          // Extra block: only the carried pad byte and the length.
          for (int unsigned j = 0; j < BLOCK_WORDS; j++) r_buf[j] <= '0;
          r_buf[0]                   <= r_carry ? PAD_WORD : '0;
          r_buf[WIDX_W'(LEN_WORD_HI)] <= r_cnt[CNT_W-1:WORD_W];
          r_buf[WIDX_W'(LEN_WORD_LO)] <= r_cnt[WORD_W-1:0];
          r_final                    <= 1'b1;
          r_pend_extra               <= 1'b0;
          r_carry                    <= 1'b0;
        end else begin
          for (int unsigned j = 0; j < BLOCK_WORDS; j++) begin
            if ((WIDX_W+1)'(j) > {1'b0, r_widx})
              r_buf[j] <= ((WIDX_W+1)'(j) == w_padw) ? PAD_WORD : '0;
          end
          if (w_padw <= (WIDX_W+1)'(LEN_WORD_HI - 1)) begin
            r_buf[WIDX_W'(LEN_WORD_HI)] <= r_cnt[CNT_W-1:WORD_W];
            r_buf[WIDX_W'(LEN_WORD_LO)] <= r_cnt[WORD_W-1:0];
            r_final                    <= 1'b1;
          end else begin
            // No room for the length: this block goes out non-final.
            r_final      <= 1'b0;
            r_pend_extra <= 1'b1;
            r_carry      <= (w_padw == (WIDX_W+1)'(BLOCK_WORDS));
          end
        end
      end

      if (w_issue_go) r_first <= 1'b0;

      if (w_wait_done && r_final) begin
        r_cnt   <= '0;
        r_first <= 1'b1;
        r_widx  <= '0;
        r_busy  <= 1'b0;
      end
    end
  end

  // Flatten the buffer, word 0 in the most significant position.
  always_comb begin
    blk = '0;
    for (int unsigned j = 0; j < BLOCK_WORDS; j++)
      blk[BLK_W-1-j*WORD_W -: WORD_W] = r_buf[j];
  end

  assign s_ready  = r_s_ready;
  assign blk_init = r_blk_init;
  assign blk_next = r_blk_next;
  assign msg_done = r_msg_done;
  assign busy     = r_busy;

endmodule

// File: tb/tb_sha1_msg_padder.sv
// Bench for sha1_msg_padder: a table of message lengths with hand-computed
// padding results, checked against a byte-level padding reference, plus
// directed sequences for core back-pressure and reset during WAIT.
module tb_sha1_msg_padder;

  logic         clk;
  logic         reset_n;
  logic         s_valid;
  logic         s_ready;
  logic [31:0]  s_data;
  logic         s_last;
  logic [1:0]   s_bytes;
  logic [511:0] blk;
  logic         blk_init;
  logic         blk_next;
  logic         core_ready;
  logic         core_digest_valid;
  logic         msg_done;
  logic         busy;

  int checks   = 0;
  int failures = 0;

  sha1_msg_padder dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .s_valid           (s_valid),
    .s_ready           (s_ready),
    .s_data            (s_data),
    .s_last            (s_last),
    .s_bytes           (s_bytes),
    .blk               (blk),
    .blk_init          (blk_init),
    .blk_next          (blk_next),
    .core_ready        (core_ready),
    .core_digest_valid (core_digest_valid),
    .msg_done          (msg_done),
    .busy              (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Captured issued blocks and pulse kinds.
  logic [511:0] cap_blk[$];
  logic         cap_init[$];
  int           n_done   = 0;
  int           dv_delay = 0;

  // Simple hash-core model: digest valid a few cycles after each issue pulse.
  always @(negedge clk) begin
    core_digest_valid = 1'b0;
    if (!reset_n) begin
      dv_delay = 0;
    end else begin
      if (msg_done) n_done++;
      if (blk_init || blk_next) begin
        cap_blk.push_back(blk);
        cap_init.push_back(blk_init);
        dv_delay = 3;
      end else if (dv_delay > 0) begin
        dv_delay--;
        if (dv_delay == 0) core_digest_valid = 1'b1;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] get_word(input logic [511:0] b, input int w);
    return b[511-32*w -: 32];
  endfunction

  // Byte-level SHA-1 padding reference: msg || 0x80 || zeros || len64.
  function automatic logic [7:0] ref_byte(input int len, input int p);
    int nblk;
    int q;
    logic [63:0] bits;
    nblk = (len + 8) / 64 + 1;
    bits = 64'(len) * 64'd8;
    q    = p - (nblk * 64 - 8);
    if (p < len)  return 8'(32'h61 + p);
    if (p == len) return 8'h80;
    if (q >= 0)   return bits[63-8*q -: 8];
    return 8'h00;
  endfunction

  function automatic logic [31:0] ref_word(input int len, input int g);
    return {ref_byte(len, 4*g), ref_byte(len, 4*g+1), ref_byte(len, 4*g+2), ref_byte(len, 4*g+3)};
  endfunction

  // Input word: message bytes 0x61+n, invalid tail bytes filled with 0xFF.
  function automatic logic [31:0] msg_word(input int len, input int w);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) begin
      r[31-8*b -: 8] = (4*w + b < len) ? 8'(32'h61 + 4*w + b) : 8'hFF;
    end
    return r;
  endfunction

  task automatic send_msg(input int len);
    int nw;
    nw = (len + 3) / 4;
    for (int i = 0; i < nw; i++) begin
      int guard;
      guard   = 0;
      s_valid = 1'b1;
      s_data  = msg_word(len, i);
      s_last  = (i == nw - 1);
      s_bytes = (i == nw - 1) ? 2'(len % 4) : 2'd0;
      while (!s_ready && guard < 300) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 300) check($sformatf("s_ready_timeout_len%0d", len), 64'(s_ready), 64'd1);
      @(negedge clk);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_bytes = 2'd0;
  endtask

  task automatic wait_done(input int target, input string name);
    int guard;
    guard = 0;
    while (n_done < target && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    check({name, "_done"}, 64'(n_done), 64'(target));
  endtask

  typedef struct {
    int          len;
    int          nblk;
    int          padw;    // global word index holding 0x80
    logic [31:0] padval;
    logic [31:0] len_lo;
  } vec_t;

  vec_t vecs[11];

  task automatic run_vec(input vec_t v);
    int    target;
    int    errs;
    int    nb;
    string nm;
    nm = $sformatf("len%0d", v.len);
    cap_blk.delete();
    cap_init.delete();
    target = n_done + 1;
    send_msg(v.len);
    wait_done(target, nm);
    nb = cap_blk.size();
    check({nm, "_nblk"}, 64'(nb), 64'(v.nblk));
    if (nb == v.nblk) begin
      errs = 0;
      for (int i = 0; i < nb; i++) begin
        if (cap_init[i] !== (i == 0)) errs++;
      end
      check({nm, "_pulse_kinds_bad"}, 64'(errs), 64'd0);
      check({nm, "_padword"}, 64'(get_word(cap_blk[v.padw / 16], v.padw % 16)), 64'(v.padval));
      check({nm, "_len_lo"}, 64'(get_word(cap_blk[nb-1], 15)), 64'(v.len_lo));
      check({nm, "_len_hi"}, 64'(get_word(cap_blk[nb-1], 14)), 64'd0);
      errs = 0;
      for (int g = 0; g < nb * 16; g++) begin
        if (get_word(cap_blk[g / 16], g % 16) !== ref_word(v.len, g)) begin
          if (errs == 0)
            $display("FAIL %s_word%0d: got %h expected %h", nm, g,
                     get_word(cap_blk[g / 16], g % 16), ref_word(v.len, g));
          errs++;
        end
      end
      check({nm, "_words_bad"}, 64'(errs), 64'd0);
    end
    check({nm, "_busy_after"}, 64'(busy), 64'd0);
  endtask

  initial begin
    logic [511:0] snap;
    logic         stable;
    logic         nopulse;
    logic         rdy0;
    int           guard;
    int           target;

    vecs[0]  = '{len: 3,   nblk: 1, padw: 0,  padval: 32'h61626380, len_lo: 32'h00000018};
    vecs[1]  = '{len: 1,   nblk: 1, padw: 0,  padval: 32'h61800000, len_lo: 32'h00000008};
    vecs[2]  = '{len: 2,   nblk: 1, padw: 0,  padval: 32'h61628000, len_lo: 32'h00000010};
    vecs[3]  = '{len: 4,   nblk: 1, padw: 1,  padval: 32'h80000000, len_lo: 32'h00000020};
    vecs[4]  = '{len: 55,  nblk: 1, padw: 13, padval: 32'h95969780, len_lo: 32'h000001B8};
    vecs[5]  = '{len: 56,  nblk: 2, padw: 14, padval: 32'h80000000, len_lo: 32'h000001C0};
    vecs[6]  = '{len: 60,  nblk: 2, padw: 15, padval: 32'h80000000, len_lo: 32'h000001E0};
    vecs[7]  = '{len: 63,  nblk: 2, padw: 15, padval: 32'h9D9E9F80, len_lo: 32'h000001F8};
    vecs[8]  = '{len: 64,  nblk: 2, padw: 16, padval: 32'h80000000, len_lo: 32'h00000200};
    vecs[9]  = '{len: 70,  nblk: 2, padw: 17, padval: 32'hA5A68000, len_lo: 32'h00000230};
    vecs[10] = '{len: 120, nblk: 3, padw: 30, padval: 32'h80000000, len_lo: 32'h000003C0};

    reset_n    = 1'b0;
    s_valid    = 1'b0;
    s_data     = 32'h0;
    s_last     = 1'b0;
    s_bytes    = 2'd0;
    core_ready = 1'b1;

    // Reset values.
    repeat (2) @(negedge clk);
    check("rst_s_ready",  64'(s_ready),  64'd0);
    check("rst_blk",      64'(blk == '0), 64'd1);
    check("rst_pulses",   64'({blk_init, blk_next, msg_done}), 64'd0);
    check("rst_busy",     64'(busy),     64'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_s_ready", 64'(s_ready), 64'd1);

    // Table of lengths.
    foreach (vecs[i]) run_vec(vecs[i]);

    // Core back-pressure: hold core_ready low while the block waits in ISSUE.
    cap_blk.delete();
    cap_init.delete();
    core_ready = 1'b0;
    target     = n_done + 1;
    send_msg(3);
    @(negedge clk);
    snap    = blk;
    stable  = 1'b1;
    nopulse = 1'b1;
    rdy0    = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (blk !== snap) stable = 1'b0;
      if (blk_init || blk_next) nopulse = 1'b0;
      if (s_ready) rdy0 = 1'b0;
    end
    check("hold_blk_stable", 64'(stable),  64'd1);
    check("hold_no_pulse",   64'(nopulse), 64'd1);
    check("hold_s_ready_lo", 64'(rdy0),    64'd1);
    check("hold_busy",       64'(busy),    64'd1);
    core_ready = 1'b1;
    @(negedge clk);
    check("hold_release_init", 64'(blk_init), 64'd1);
    wait_done(target, "hold");
    check("hold_word0",  64'(get_word(snap, 0)),  64'h61626380);
    check("hold_word15", 64'(get_word(snap, 15)), 64'h00000018);

    // Reset during WAIT of block 1 of a 2-block message, then "abc".
    cap_blk.delete();
    cap_init.delete();
    send_msg(64);
    guard = 0;
    while (cap_blk.size() == 0 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    check("midrst_first_issue", 64'(cap_blk.size()), 64'd1);
    reset_n = 1'b0;
    #1;
    check("midrst_busy",    64'(busy),    64'd0);
    check("midrst_s_ready", 64'(s_ready), 64'd0);
    check("midrst_blk",     64'(blk == '0), 64'd1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    run_vec(vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sha1_msg_padder.md
SHA1_MSG_PADDER -- requirements
Module: sha1_msg_padder

Interface
REQ-001 SHALL have clk  in  1  rising-edge clock.
REQ-002 SHALL have reset_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have s_valid  in  1  message word valid.
REQ-004 SHALL have s_ready  out  1  padder accepts the word this cycle.
REQ-005 SHALL have s_data  in  32  message word, big-endian: the first byte is in [31:24].
REQ-006 SHALL have s_last  in  1  the current word is the final word of the message.
REQ-007 SHALL have s_bytes  in  2  valid bytes in the final word: 0 means 4, 1..3 mean 1..3; the valid bytes are MSB-aligned; ignored unless s_last.
REQ-008 SHALL have blk  out  512  padded block; word 0 is at [511:480].
REQ-009 SHALL have blk_init  out  1  one-cycle pulse that issues the first block of a message.
REQ-010 SHALL have blk_next  out  1  one-cycle pulse that issues each later block of a message.
REQ-011 SHALL have core_ready  in  1  the hash core is idle and can take init/next.
REQ-012 SHALL have core_digest_valid  in  1  the hash core has finished the current block.
REQ-013 SHALL have msg_done  out  1  one-cycle pulse when the digest of the message's final block is valid.
REQ-014 SHALL have busy  out  1  high from the first accepted word until msg_done.

Function
REQ-015 SHALL implement these FSM states: FILL, PAD, ISSUE, WAIT.
REQ-016 FILL: s_ready=1; each handshake (s_valid&&s_ready) SHALL write s_data to buffer word widx, with invalid bytes of a final word forced to 0, then widx+1.
REQ-017 SHALL keep a 64-bit bit counter; add 32 per non-final word and 8*k per final word (k=1..4); the counter wraps modulo 2^64.
REQ-018 Final word at index i with k<4: SHALL place 0x80 in byte k of word i.
REQ-019 Final word at index i with k=4: SHALL set word i+1 to 0x80000000 if i<15; if i=15, SHALL carry the pad byte to word 0 of the next block.
REQ-020 If the 0x80 byte lands in word ≤13: SHALL zero-fill through word 13, put the counter in words 14 (high) and 15 (low), and mark the block final.
REQ-021 Otherwise: SHALL zero-fill the remaining words, issue the block as non-final, then build an extra block of all zeros (0x80000000 in word 0 if carried) plus the length in words 14–15, marked final.
REQ-022 Zero-fill and length insertion SHALL complete in the single PAD cycle; the latency from the final handshake to ISSUE is 1 cycle.
REQ-023 A non-final handshake at widx=15 SHALL go directly to ISSUE (non-final), then return to FILL with widx=0.
REQ-024 ISSUE: blk stable; when core_ready=1, SHALL pulse blk_init for the message's first block and blk_next otherwise, for exactly 1 cycle, then go to WAIT.
REQ-025 ISSUE with core_ready=0: SHALL hold, with no pulse.
REQ-026 WAIT: SHALL stay until core_digest_valid=1.
REQ-027 On leaving WAIT: a final block SHALL pulse msg_done and go to FILL, clearing the counter, the first flag and widx; a non-final block SHALL go to FILL, or to PAD for a pending extra block.
REQ-028 blk SHALL stay constant from ISSUE through WAIT.
REQ-029 s_ready SHALL be 0 outside FILL.
REQ-030 A message SHALL contain ≥1 byte; a zero-length message is unsupported.
REQ-031 s_last together with the widx=15 wrap SHALL take the padding path, not REQ-023.

Reset
REQ-032 On reset_n=0: state FILL, widx 0, counter 0, buffer 0, first flag set, pending-extra clear.
REQ-033 On reset_n=0: s_ready=0 while in reset, then 1; blk=0; blk_init=blk_next=msg_done=busy=0.
REQ-034 Reset mid-message SHALL discard all partial state, and the next message SHALL restart with blk_init.

Structure
REQ-035 Shared package sha1_pkg SHALL hold: the FSM state enum, PAD_BYTE=8'h80, LEN_WORD_HI=14, LEN_WORD_LO=15, BLOCK_WORDS=16.
REQ-036 SHALL be a single module with no sub-module; the buffer is a 16x32 register array.

Verification
REQ-037 Message "abc" (one word 0x61626300, s_last, s_bytes=3) -> blk word0=0x61626380, words1–14=0, word15=0x00000018; one blk_init; msg_done after core_digest_valid.
REQ-038 55-byte message (13 full words plus final k=3) -> one block; 0x80 in word 13 byte 3; word15=0x000001B8.
REQ-039 56-byte message (final word at i=13, k=4) -> block 1 word14=0x80000000, word15=0 via blk_init; block 2 words0–14=0, word15=0x000001C0 via blk_next.
REQ-040 64-byte message -> block 1 = data only; block 2 word0=0x80000000, word15=0x00000200, issued via blk_next.
REQ-041 core_ready held 0 for 10 cycles in ISSUE -> no pulse and blk stable; pulse in the first cycle core_ready=1.
REQ-042 Assert reset_n=0 in WAIT of block 1 of a 2-block message, then send "abc" -> the REQ-037 result with blk_init.
